// File: rtl/renkon_ctrl_layer.sv
// renkon_ctrl_layer: sequences one conv layer run, streaming each input channel's pixels
// per output group, then draining the pipeline and waiting for the output stage.
module renkon_ctrl_layer #(
  parameter int LWIDTH  = 10,
  parameter int IMGSIZE = 12,
  parameter int DRAIN   = 8
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [LWIDTH-1:0]  w_img_size,
  input  logic [LWIDTH-1:0]  w_fil_size,
  input  logic [LWIDTH-1:0]  w_num_in,
  input  logic [LWIDTH-1:0]  w_num_out,
  input  logic               out_end,
  output logic               ack,
  output logic [1:0]         core_state,
  output logic               in_begin,
  output logic               in_valid,
  output logic               in_end,
  output logic               first_input,
  output logic               last_input,
  output logic [IMGSIZE-1:0] img_addr,
  output logic [LWIDTH-1:0]  img_size,
  output logic [LWIDTH-1:0]  fil_size
);
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0] DLAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);
  typedef enum logic [2:0] {S_IDLE, S_BEGIN, S_STREAM, S_DRAIN, S_OUTPUT, S_DONE} state_t;
  state_t r_state;
  logic [LWIDTH-1:0] r_num_in, r_num_out, r_ch, r_grp, r_x, r_y;
  logic [DW-1:0] r_dcnt;
  logic w_zero;
  logic [LWIDTH-1:0] w_img_m1, w_ch_n;
  assign w_zero   = (w_img_size == '0) || (w_num_in == '0) || (w_num_out == '0);
  assign w_img_m1 = img_size - LWIDTH'(1);
  assign w_ch_n   = r_ch + LWIDTH'(1);
  // in_end is registered one cycle ahead, so it doubles as the "current pixel is last" flag
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= S_IDLE;
      {ack, core_state, in_begin, in_valid, in_end, first_input, last_input} <= '0;
      img_addr <= '0;
      {img_size, fil_size, r_num_in, r_num_out, r_ch, r_grp, r_x, r_y} <= '0;
      r_dcnt <= '0;
    end else begin
      in_begin <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: if (req) begin
          img_size  <= w_img_size;
          fil_size  <= w_fil_size;
          r_num_in  <= w_num_in;
          r_num_out <= w_num_out;
          {r_ch, r_grp, r_x, r_y} <= '0;
          img_addr  <= '0;
          r_dcnt    <= '0;
          r_state    <= w_zero ? S_DONE : S_BEGIN;
          ack        <= w_zero;
          core_state <= w_zero ? 2'd0 : 2'd2;
          in_begin   <= !w_zero;
          first_input <= !w_zero;
          last_input  <= !w_zero && (w_num_in == LWIDTH'(1));
        end
        S_BEGIN: begin
          r_state  <= S_STREAM;
          in_valid <= 1'b1;
          in_end   <= (img_size == LWIDTH'(1));
          r_x      <= '0;
          r_y      <= '0;
        end
        S_STREAM: begin
          img_addr <= img_addr + IMGSIZE'(1);
          if (in_end) begin
            in_valid <= 1'b0;
            in_end   <= 1'b0;
            if (last_input) begin
              r_dcnt     <= '0;
              r_state    <= (DRAIN == 0) ? S_OUTPUT : S_DRAIN;
              core_state <= (DRAIN == 0) ? 2'd3 : 2'd2;
            end else begin
              r_ch        <= w_ch_n;
              r_state     <= S_BEGIN;
              in_begin    <= 1'b1;
              first_input <= 1'b0;
              last_input  <= (w_ch_n == r_num_in - LWIDTH'(1));
            end
          end else begin
            in_end <= (r_y == w_img_m1) && (r_x + LWIDTH'(1) == w_img_m1);
            r_x    <= (r_x == w_img_m1) ? '0 : r_x + LWIDTH'(1);
            r_y    <= (r_x == w_img_m1) ? r_y + LWIDTH'(1) : r_y;
          end
        end
        S_DRAIN: begin
          r_dcnt     <= r_dcnt + DW'(1);
          r_state    <= (r_dcnt == DLAST) ? S_OUTPUT : S_DRAIN;
          core_state <= (r_dcnt == DLAST) ? 2'd3 : 2'd2;
        end
        S_OUTPUT: if (out_end) begin
          if (r_grp != r_num_out - LWIDTH'(1)) begin
            r_grp       <= r_grp + LWIDTH'(1);
            r_ch        <= '0;
            img_addr    <= '0;
            r_state     <= S_BEGIN;
            core_state  <= 2'd2;
            in_begin    <= 1'b1;
            first_input <= 1'b1;
            last_input  <= (r_num_in == LWIDTH'(1));
          end else begin
            r_state    <= S_DONE;
            ack        <= 1'b1;
            core_state <= 2'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_renkon_ctrl_layer.sv
// tb_renkon_ctrl_layer: scoreboard bench; a layer model queues every expected strobe with its
// cycle, a negedge monitor pops and compares whenever in_begin or in_valid is seen.
module tb_renkon_ctrl_layer;
  localparam int LW = 10, IS = 6, DR = 8;
  localparam int AMOD = 1 << IS;
  logic clk = 0, xrst = 0, req = 0, out_end = 0;
  logic [LW-1:0] w_img_size = 0, w_fil_size = 0, w_num_in = 0, w_num_out = 0;
  logic ack, in_begin, in_valid, in_end, first_input, last_input;
  logic [1:0] core_state;
  logic [IS-1:0] img_addr;
  logic [LW-1:0] img_size, fil_size;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int cyc; bit beg; int addr; bit e; bit f; bit l;} exp_t;
  exp_t q[$];

  renkon_ctrl_layer #(.LWIDTH(LW), .IMGSIZE(IS), .DRAIN(DR)) dut (
    .clk(clk), .xrst(xrst), .req(req), .w_img_size(w_img_size), .w_fil_size(w_fil_size),
    .w_num_in(w_num_in), .w_num_out(w_num_out), .out_end(out_end), .ack(ack),
    .core_state(core_state), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
    .first_input(first_input), .last_input(last_input), .img_addr(img_addr),
    .img_size(img_size), .fil_size(fil_size));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (in_begin || in_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe at cycle %0d: begin=%0d valid=%0d expected none", cyc, in_begin, in_valid);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("in_begin", in_begin, e.beg);
        chk("in_valid", in_valid, !e.beg);
        if (!e.beg) begin
          chk("img_addr", img_addr, e.addr);
          chk("in_end", in_end, e.e);
        end
        chk("first_input", first_input, e.f);
        chk("last_input", last_input, e.l);
        chk("core_state_in", core_state, 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic run_layer(input int img, fil, nin, nout, odly, input bit ign, input int rst_beat);
    int t, b, n2, g0;
    int os[$];
    bit zero;
    step();
    t = cyc;
    w_img_size = LW'(img); w_fil_size = LW'(fil); w_num_in = LW'(nin); w_num_out = LW'(nout);
    req = 1;
    zero = (img == 0) || (nin == 0) || (nout == 0);
    n2 = img * img;
    g0 = t;
    if (!zero)
      for (int g = 0; g < nout; g++) begin
        b = g0 + 1;
        for (int c = 0; c < nin; c++) begin
          q.push_back('{b, 1'b1, 0, 1'b0, c == 0, c == nin - 1});
          for (int p = 0; p < n2; p++)
            q.push_back('{b + 1 + p, 1'b0, (c * n2 + p) % AMOD, p == n2 - 1, c == 0, c == nin - 1});
          b += n2 + 1;
        end
        os.push_back(b + DR);
        g0 = b + DR + odly;
      end
    step();
    req = 0;
    w_img_size = LW'($urandom_range(0, 15)); w_num_in = LW'($urandom_range(0, 3));
    chk("img_size_latch", img_size, img);
    chk("fil_size_latch", fil_size, fil);
    chk("ack_after_req", ack, zero);
    chk("core_state_after_req", core_state, zero ? 0 : 2);
    if (zero) return;
    if (ign) begin
      wait_cyc(t + 3);
      req = 1; out_end = 1; w_img_size = LW'(img + 1);
      step();
      req = 0; out_end = 0;
    end
    if (rst_beat > 0) begin
      wait_cyc(t + 1 + rst_beat);
      @(negedge clk);
      #1;
      xrst = 0;
      #1;
      chk("midrun_reset_zero", |{ack, core_state, in_begin, in_valid, in_end, first_input,
                                  last_input, img_addr, img_size, fil_size}, 0);
      q.delete();
      step();
      xrst = 1;
      step();
      chk("post_reset_state", core_state, 0);
      chk("post_reset_valid", in_valid, 0);
      return;
    end
    for (int g = 0; g < nout; g++) begin
      wait_cyc(os[g] - 1);
      chk("core_state_drain", core_state, 2);
      step();
      chk("core_state_output", core_state, 3);
      chk("ack_in_output", ack, 0);
      wait_cyc(os[g] + odly);
      out_end = 1;
      step();
      out_end = 0;
      chk("ack_after_out_end", ack, g == nout - 1);
      chk("core_state_after_out_end", core_state, (g == nout - 1) ? 0 : 2);
    end
    chk("scoreboard_drained", q.size(), 0);
    chk("img_size_hold", img_size, img);
  endtask

  initial begin
    #1;
    chk("reset_zero", |{ack, core_state, in_begin, in_valid, in_end, first_input,
                        last_input, img_addr, img_size, fil_size}, 0);
    step();
    step();
    xrst = 1;
    step();
    chk("idle_after_release", core_state, 0);
    run_layer(4, 3, 2, 1, 7, 0, 0);
    run_layer(2, 3, 1, 2, 2, 0, 0);
    run_layer(4, 3, 0, 1, 0, 0, 0);
    run_layer(3, 5, 2, 1, 1, 1, 0);
    run_layer(8, 3, 2, 1, 0, 0, 0);
    run_layer(1, 1, 3, 2, 0, 0, 0);
    run_layer(4, 3, 2, 1, 0, 0, 5);
    run_layer(4, 3, 2, 1, 3, 0, 0);
    for (int i = 0; i < 14; i++) begin
      int img, nin, nout;
      img  = $urandom_range(1, 6);
      nin  = $urandom_range(1, 3);
      nout = $urandom_range(1, 3);
      if (i % 5 == 4) begin
        case ($urandom_range(0, 2))
          0: img = 0;
          1: nin = 0;
          default: nout = 0;
        endcase
      end
      run_layer(img, $urandom_range(1, 7), nin, nout, $urandom_range(0, 3), img > 1 && i % 3 == 0, 0);
    end
    repeat (3) step();
    chk("final_scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
